sequenciador_rega: RTL and testbench

- Downstream actuator sequencer for the combinational irrigation decision stage.
- Consumes the sprinkler request (Bs) and drip request (Vs) from that stage, plus the error flag.
- Drives the physical pump, the sprinkler supply valve and the drip valve with safe ordering, minimum on/off times, a run-time watchdog and fault latching.
- Counters advance only on a one-cycle time-base pulse, so durations are expressed in ticks.

---
 rtl/sequenciador_rega.sv | 140 ++++++++++++++
 tb/tb_sequenciador_rega.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sequenciador_rega.sv
// sequenciador_rega: pump / sprinkler valve / drip valve sequencer.
// Safe ordering, minimum on/off times, run watchdog and fault latch.
module sequenciador_rega #(
  parameter int CW        = 8,
  parameter int OPEN_DLY  = 4,
  parameter int MIN_ON    = 8,
  parameter int DRAIN_DLY = 4,
  parameter int MIN_OFF   = 6,
  parameter int MAX_ON    = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       Bs,
  input  logic       Vs,
  input  logic       ERRO,
  output logic       BOMBA,
  output logic       VALV_ASP,
  output logic       VALV_GOT,
  output logic       FALHA,
  output logic [2:0] ESTADO
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ASP_PRE  = 3'd1,
    S_ASP_RUN  = 3'd2,
    S_ASP_POS  = 3'd3,
    S_GOT_RUN  = 3'd4,
    S_BLOQUEIO = 3'd5,
    S_FALHA    = 3'd6
  } state_t;

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] OPEN_LAST = CW'(OPEN_DLY - 1);
  localparam logic [CW-1:0] DRN_LAST  = CW'(DRAIN_DLY - 1);
  localparam logic [CW-1:0] OFF_LAST  = CW'(MIN_OFF - 1);
  localparam logic [CW:0]   MIN_ON_W  = (CW+1)'(MIN_ON);
  localparam logic [CW:0]   MAX_ON_W  = (CW+1)'(MAX_ON);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bomba_q, asp_q, got_q, falha_q;
  logic [2:0]    estado_q;

  // ticks elapsed in the state, counting the tick of this cycle
  logic [CW:0] ticks_incl;
  logic        open_done, drain_done, off_done;
  logic        min_on_ok, wdog_hit;

  assign ticks_incl = {1'b0, cnt_q} + {{CW{1'b0}}, tick};
  assign open_done  = tick && (cnt_q == OPEN_LAST);
  assign drain_done = tick && (cnt_q == DRN_LAST);
  assign off_done   = tick && (cnt_q == OFF_LAST);
  assign min_on_ok  = ticks_incl >= MIN_ON_W;
  assign wdog_hit   = ticks_incl >= MAX_ON_W;

  // next-state logic; an error pre-empts every state except the fault one
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (Bs)
          state_d = S_ASP_PRE;
        else if (Vs)
          state_d = S_GOT_RUN;
      end
      S_ASP_PRE: begin
        if (open_done)
          state_d = S_ASP_RUN;
      end
      S_ASP_RUN: begin
        if (min_on_ok && !Bs)
          state_d = S_ASP_POS;
        else if (wdog_hit)
          state_d = S_FALHA;
      end
      S_ASP_POS: begin
        if (drain_done)
          state_d = S_BLOQUEIO;
      end
      S_GOT_RUN: begin
        if (min_on_ok && !Vs)
          state_d = S_BLOQUEIO;
        else if (wdog_hit)
          state_d = S_FALHA;
      end
      S_BLOQUEIO: begin
        if (off_done)
          state_d = S_IDLE;
      end
      S_FALHA: begin
        if (!ERRO)
          state_d = S_BLOQUEIO;
      end
      default: state_d = S_IDLE;
    endcase
    if (ERRO && (state_q != S_FALHA))
      state_d = S_FALHA;
  end

  // tick counter: restarts on each transition, saturates instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (tick && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  // state, counter and Moore outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bomba_q  <= 1'b0;
      asp_q    <= 1'b0;
      got_q    <= 1'b0;
      falha_q  <= 1'b0;
      estado_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bomba_q  <= (state_d == S_ASP_RUN);
      asp_q    <= (state_d == S_ASP_PRE) ||
                  (state_d == S_ASP_RUN) ||
                  (state_d == S_ASP_POS);
      got_q    <= (state_d == S_GOT_RUN);
      falha_q  <= (state_d == S_FALHA);
      estado_q <= state_d;
    end
  end

  assign BOMBA    = bomba_q;
  assign VALV_ASP = asp_q;
  assign VALV_GOT = got_q;
  assign FALHA    = falha_q;
  assign ESTADO   = estado_q;

endmodule

// File: tb/tb_sequenciador_rega.sv
// tb_sequenciador_rega: directed bench for the irrigation sequencer.
// Expected state/output patterns are hand-derived from the tick timing.
module tb_sequenciador_rega;

  logic       clk = 1'b0;
  logic       rst, tick, Bs, Vs, ERRO;
  logic       BOMBA, VALV_ASP, VALV_GOT, FALHA;
  logic [2:0] ESTADO;

  int nchk = 0;
  int nerr = 0;

  sequenciador_rega dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .Bs      (Bs),
    .Vs      (Vs),
    .ERRO    (ERRO),
    .BOMBA   (BOMBA),
    .VALV_ASP(VALV_ASP),
    .VALV_GOT(VALV_GOT),
    .FALHA   (FALHA),
    .ESTADO  (ESTADO)
  );

  always #5 clk = ~clk;

  // {ESTADO, BOMBA, VALV_ASP, VALV_GOT, FALHA} expected for a state code
  function automatic logic [6:0] exp_o(input int st);
    logic [3:0] f;
    case (st)
      0: f = 4'b0000;
      1: f = 4'b0100;
      2: f = 4'b1100;
      3: f = 4'b0100;
      4: f = 4'b0010;
      5: f = 4'b0000;
      6: f = 4'b0001;
      default: f = 4'b0000;
    endcase
    return {3'(st), f};
  endfunction

  function automatic logic [6:0] obs_o();
    return {ESTADO, BOMBA, VALV_ASP, VALV_GOT, FALHA};
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs,
                     input logic [6:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // advance n edges, checking the state pattern and invariants after each
  task automatic run(input string tag, input int n, input int st);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk(tag, obs_o(), exp_o(st));
      chk({tag, "_inv"},
          {5'd0, BOMBA & ~VALV_ASP, VALV_GOT & VALV_ASP}, 7'd0);
    end
  endtask

  initial begin
    int nt;
    rst = 1'b1; tick = 1'b0; Bs = 1'b0; Vs = 1'b0; ERRO = 1'b0;
    cyc();
    chk("reset", obs_o(), exp_o(0));
    rst = 1'b0;
    run("idle_hold", 2, 0);

    // sprinkler cycle
    tick = 1'b1; Bs = 1'b1;
    run("asp_pre", 4, 1);
    run("asp_run", 16, 2);
    Bs = 1'b0;
    run("asp_pos", 4, 3);
    run("asp_blk", 6, 5);
    run("asp_idle", 1, 0);

    // drip run held to minimum on time
    Vs = 1'b1;
    run("got_run_a", 1, 4);
    Vs = 1'b1;
    run("got_run_b", 1, 4);
    Vs = 1'b0;
    run("got_minon", 6, 4);
    run("got_blk", 6, 5);
    run("got_idle", 1, 0);

    // simultaneous requests, drip request ignored during sprinkler run
    Bs = 1'b1; Vs = 1'b1;
    run("sim_pre", 4, 1);
    run("sim_run0", 1, 2);
    Bs = 1'b0;
    run("sim_run", 7, 2);
    run("sim_pos", 4, 3);
    run("sim_blk", 6, 5);
    run("sim_idle", 1, 0);
    run("sim_got", 1, 4);
    Vs = 1'b0;
    run("sim_got_on", 7, 4);
    run("sim_got_blk", 6, 5);
    run("sim_got_idle", 1, 0);

    // fault in the middle of a sprinkler run
    Bs = 1'b1;
    run("flt_pre", 4, 1);
    run("flt_run", 3, 2);
    ERRO = 1'b1;
    run("flt_set", 3, 6);
    ERRO = 1'b0; Bs = 1'b0;
    run("flt_clr", 6, 5);
    run("flt_idle", 1, 0);

    // watchdog with a tick on every 4th cycle
    tick = 1'b0; Vs = 1'b1;
    run("wd_start", 1, 4);
    nt = 0;
    for (int k = 0; k < 400; k++) begin
      tick = (k % 4 == 3);
      if (tick) nt++;
      run("wd_run", 1, (nt >= 100) ? 6 : 4);
    end
    tick = 1'b0; Vs = 1'b0;
    run("wd_exit", 1, 5);
    run("stall", 50, 5);
    ERRO = 1'b1;
    run("stall_err", 1, 6);
    ERRO = 1'b0;
    run("stall_exit", 1, 5);
    tick = 1'b1;
    run("stall_blk", 5, 5);
    run("stall_idle", 1, 0);

    // synchronous reset in the middle of a run, then fresh restart
    Bs = 1'b1;
    run("rr_pre", 4, 1);
    run("rr_run", 3, 2);
    rst = 1'b1;
    run("rr_reset", 1, 0);
    rst = 1'b0;
    run("rr_pre2", 4, 1);
    run("rr_run2", 1, 2);
    Bs = 1'b0;
    run("rr_minon", 7, 2);
    run("rr_pos", 4, 3);
    run("rr_blk", 6, 5);
    run("rr_idle", 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
